// File: rtl/ahb_slave_if.sv
// AHB slave front end for an AHB-to-APB bridge: address decode, transfer
// qualification, address/data pipeline and the two-cycle ERROR response FSM.
module ahb_slave_if (
  input  logic        CLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY_IN,
  input  logic        APB_READY,
  output logic        VALID,
  output logic [2:0]  TEMP_SEL,
  output logic [31:0] HADDR_1,
  output logic [31:0] HADDR_2,
  output logic [31:0] HWDATA_1,
  output logic [31:0] HWDATA_2,
  output logic        HWRITE_REG,
  output logic        HREADY_OUT,
  output logic [1:0]  HRESP
);

  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic [31:0] haddr_1_q, haddr_2_q, hwdata_1_q, hwdata_2_q;
  logic        hwrite_q;
  logic        active, aligned, legal;

  // Each peripheral owns one 64 MB window starting at 0x8000_0000.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_decode
      assign TEMP_SEL[gi] = (HADDR[31:26] == 6'(32 + gi));
    end
  endgenerate

  always_comb begin
    aligned = 1'b0;
    case (HSIZE)
      3'b000:  aligned = 1'b1;
      3'b001:  aligned = ~HADDR[0];
      3'b010:  aligned = (HADDR[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign active = HREADY_IN & HTRANS[1];
  assign legal  = (|TEMP_SEL) & aligned;

  always_ff @(posedge CLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_OKAY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    VALID      = 1'b0;
    HRESP      = 2'b00;
    HREADY_OUT = APB_READY;
    case (state_q)
      S_OKAY: begin
        VALID = active & legal;
        if (active && !legal) state_d = S_ERR1;
      end
      S_ERR1: begin
        HRESP      = 2'b01;
        HREADY_OUT = 1'b0;
        state_d    = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 2'b01;
        HREADY_OUT = 1'b1;
        state_d    = S_OKAY;
      end
      default: state_d = S_OKAY;
    endcase
    // Reset must show an idle, ready slave even before any clock edge.
    if (HRESET) begin
      VALID      = 1'b0;
      HRESP      = 2'b00;
      HREADY_OUT = 1'b1;
    end
  end

  // The pipeline follows the bus-wide ready only; error state does not stall it.
  always_ff @(posedge CLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_1_q  <= '0;
      haddr_2_q  <= '0;
      hwdata_1_q <= '0;
      hwdata_2_q <= '0;
      hwrite_q   <= 1'b0;
    end else if (HREADY_IN) begin
      haddr_1_q  <= HADDR;
      haddr_2_q  <= haddr_1_q;
      hwdata_1_q <= HWDATA;
      hwdata_2_q <= hwdata_1_q;
      hwrite_q   <= HWRITE;
    end
  end

  assign HADDR_1    = haddr_1_q;
  assign HADDR_2    = haddr_2_q;
  assign HWDATA_1   = hwdata_1_q;
  assign HWDATA_2   = hwdata_2_q;
  assign HWRITE_REG = hwrite_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed vector table, hand-written
// reset/stall sequences and randomized traffic against a behavioural model.
module tb_ahb_slave_if;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSQ = 2'b10, T_SEQ = 2'b11;

  logic        CLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE, HREADY_IN, APB_READY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        VALID, HWRITE_REG, HREADY_OUT;
  logic [2:0]  TEMP_SEL;
  logic [31:0] HADDR_1, HADDR_2, HWDATA_1, HWDATA_2;
  logic [1:0]  HRESP;

  ahb_slave_if dut (
    .CLK(CLK), .HRESET(HRESET), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HSIZE(HSIZE), .HREADY_IN(HREADY_IN), .APB_READY(APB_READY),
    .VALID(VALID), .TEMP_SEL(TEMP_SEL), .HADDR_1(HADDR_1), .HADDR_2(HADDR_2),
    .HWDATA_1(HWDATA_1), .HWDATA_2(HWDATA_2), .HWRITE_REG(HWRITE_REG),
    .HREADY_OUT(HREADY_OUT), .HRESP(HRESP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  trans;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        rdy;
    logic        apb;
    logic        e_valid;
    logic [2:0]  e_sel;
    logic [1:0]  e_resp;
    logic        e_hro;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: error countdown (cycles of ERROR still to show) and
  // a two-deep history of accepted address/data.
  int          m_err;
  logic [31:0] m_a1, m_a2, m_d1, m_d2;
  logic        m_w;

  function automatic logic [2:0] m_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
    if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
    if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic m_legal(input logic [31:0] a, input logic [2:0] s);
    if (m_sel(a) == 3'b000 || s > 3'd2) return 1'b0;
    return (a % (32'd1 << s)) == 0;
  endfunction

  function automatic vec_t mkv(input logic [31:0] a, input logic w, input logic [1:0] t,
                               input logic [31:0] d, input logic [2:0] s, input logic r,
                               input logic ap, input logic ev, input logic [2:0] es,
                               input logic [1:0] er, input logic eh);
    vec_t v;
    v.addr = a; v.wr = w; v.trans = t; v.wdata = d; v.size = s; v.rdy = r; v.apb = ap;
    v.e_valid = ev; v.e_sel = es; v.e_resp = er; v.e_hro = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [1:0] t,
                       input logic [31:0] d, input logic [2:0] s, input logic r, input logic ap);
    @(negedge CLK);
    HADDR = a; HWRITE = w; HTRANS = t; HWDATA = d; HSIZE = s; HREADY_IN = r; APB_READY = ap;
    #1;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " HADDR_1"}, HADDR_1, m_a1);
    chk({tag, " HADDR_2"}, HADDR_2, m_a2);
    chk({tag, " HWDATA_1"}, HWDATA_1, m_d1);
    chk({tag, " HWDATA_2"}, HWDATA_2, m_d2);
    chk({tag, " HWRITE_REG"}, HWRITE_REG, m_w);
  endtask

  task automatic check_model_comb(input string tag);
    logic act;
    act = HREADY_IN && (HTRANS == T_NSQ || HTRANS == T_SEQ);
    chk({tag, " TEMP_SEL"}, TEMP_SEL, m_sel(HADDR));
    chk({tag, " VALID"}, VALID, (m_err == 0) && act && m_legal(HADDR, HSIZE));
    chk({tag, " HRESP"}, HRESP, (m_err != 0) ? 2'b01 : 2'b00);
    chk({tag, " HREADY_OUT"}, HREADY_OUT, (m_err == 2) ? 1'b0 : (m_err == 1) ? 1'b1 : APB_READY);
  endtask

  task automatic advance();
    logic act;
    @(posedge CLK);
    act = HREADY_IN && (HTRANS == T_NSQ || HTRANS == T_SEQ);
    if (m_err > 0) m_err--;
    else if (act && !m_legal(HADDR, HSIZE)) m_err = 2;
    if (HREADY_IN) begin
      m_a2 = m_a1; m_a1 = HADDR; m_d2 = m_d1; m_d1 = HWDATA; m_w = HWRITE;
    end
  endtask

  vec_t tbl[21];

  initial begin
    tbl[0]  = mkv(32'h8000_0010, 1, T_NSQ,  32'h0000_0000, 3'd2, 1, 1, 1, 3'b001, 2'b00, 1);
    tbl[1]  = mkv(32'h8400_0004, 0, T_NSQ,  32'hA5A5_A5A5, 3'd2, 1, 1, 1, 3'b010, 2'b00, 1);
    tbl[2]  = mkv(32'h8800_0008, 0, T_NSQ,  32'h1234_5678, 3'd2, 1, 0, 1, 3'b100, 2'b00, 0);
    tbl[3]  = mkv(32'h9000_0000, 0, T_IDLE, 32'h0000_0001, 3'd2, 1, 1, 0, 3'b000, 2'b00, 1);
    tbl[4]  = mkv(32'h9000_0000, 1, T_NSQ,  32'h0000_0002, 3'd2, 1, 1, 0, 3'b000, 2'b00, 1);
    tbl[5]  = mkv(32'h8000_0000, 1, T_NSQ,  32'h0000_0003, 3'd2, 1, 1, 0, 3'b001, 2'b01, 0);
    tbl[6]  = mkv(32'h9000_0000, 0, T_NSQ,  32'h0000_0004, 3'd2, 1, 1, 0, 3'b000, 2'b01, 1);
    tbl[7]  = mkv(32'h0000_0000, 0, T_IDLE, 32'h0000_0005, 3'd0, 1, 1, 0, 3'b000, 2'b00, 1);
    tbl[8]  = mkv(32'h8000_0002, 1, T_NSQ,  32'h0000_0006, 3'd2, 1, 1, 0, 3'b001, 2'b00, 1);
    tbl[9]  = mkv(32'h8000_0000, 0, T_BUSY, 32'h0000_0007, 3'd2, 1, 1, 0, 3'b001, 2'b01, 0);
    tbl[10] = mkv(32'h8000_0000, 0, T_IDLE, 32'h0000_0008, 3'd2, 1, 1, 0, 3'b001, 2'b01, 1);
    tbl[11] = mkv(32'h8000_0001, 0, T_NSQ,  32'h0000_0009, 3'd1, 1, 1, 0, 3'b001, 2'b00, 1);
    tbl[12] = mkv(32'h8000_0004, 0, T_SEQ,  32'h0000_000A, 3'd2, 1, 1, 0, 3'b001, 2'b01, 0);
    tbl[13] = mkv(32'h8000_0008, 0, T_SEQ,  32'h0000_000B, 3'd3, 1, 1, 0, 3'b001, 2'b01, 1);
    tbl[14] = mkv(32'h8000_0008, 0, T_SEQ,  32'h0000_000C, 3'd3, 1, 1, 0, 3'b001, 2'b00, 1);
    tbl[15] = mkv(32'h8000_0008, 1, T_NSQ,  32'h0000_000D, 3'd0, 0, 1, 0, 3'b001, 2'b01, 0);
    tbl[16] = mkv(32'h8000_0009, 1, T_NSQ,  32'h0000_000E, 3'd0, 1, 1, 0, 3'b001, 2'b01, 1);
    tbl[17] = mkv(32'h8000_0009, 1, T_NSQ,  32'h0000_000F, 3'd0, 1, 1, 1, 3'b001, 2'b00, 1);
    tbl[18] = mkv(32'h8000_0006, 0, T_NSQ,  32'h0000_0010, 3'd1, 1, 1, 1, 3'b001, 2'b00, 1);
    tbl[19] = mkv(32'h8C00_0000, 0, T_NSQ,  32'h0000_0011, 3'd0, 0, 1, 0, 3'b000, 2'b00, 1);
    tbl[20] = mkv(32'h0000_0000, 0, T_IDLE, 32'h0000_0012, 3'd0, 1, 1, 0, 3'b000, 2'b00, 1);

    // Reset with a legal transfer presented and APB not ready.
    HRESET = 1'b1; HADDR = 32'h8000_0000; HWRITE = 1'b1; HTRANS = T_NSQ;
    HWDATA = 32'hFFFF_FFFF; HSIZE = 3'd2; HREADY_IN = 1'b1; APB_READY = 1'b0;
    model_reset();
    #2;
    chk("reset VALID", VALID, 0);
    chk("reset HREADY_OUT", HREADY_OUT, 1);
    chk("reset HRESP", HRESP, 0);
    check_regs("reset");
    repeat (2) @(posedge CLK);
    #1;
    check_regs("reset held");
    HREADY_IN = 1'b0; HTRANS = T_IDLE;
    @(negedge CLK);
    HRESET = 1'b0;

    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].addr, tbl[i].wr, tbl[i].trans, tbl[i].wdata, tbl[i].size, tbl[i].rdy, tbl[i].apb);
      chk({tag, " VALID"}, VALID, tbl[i].e_valid);
      chk({tag, " TEMP_SEL"}, TEMP_SEL, tbl[i].e_sel);
      chk({tag, " HRESP"}, HRESP, tbl[i].e_resp);
      chk({tag, " HREADY_OUT"}, HREADY_OUT, tbl[i].e_hro);
      check_regs(tag);
      advance();
    end

    // Stall: three cycles of HREADY_IN=0 with a changing address.
    drive(32'h8000_0100, 1, T_IDLE, 32'h1111_1111, 3'd2, 1, 1); advance();
    drive(32'h8000_0200, 0, T_IDLE, 32'h2222_2222, 3'd2, 1, 1); advance();
    for (int k = 0; k < 3; k++) begin
      drive($urandom, 1, T_NSQ, $urandom, 3'd2, 0, 1);
      chk($sformatf("stall%0d HADDR_1", k), HADDR_1, 32'h8000_0200);
      chk($sformatf("stall%0d HADDR_2", k), HADDR_2, 32'h8000_0100);
      chk($sformatf("stall%0d HWDATA_1", k), HWDATA_1, 32'h2222_2222);
      advance();
    end

    // Reset pulsed in the middle of ERR1 aborts the error at once.
    drive(32'h9000_0000, 1, T_NSQ, 32'h3333_3333, 3'd2, 1, 1); advance();
    drive(32'h8000_0000, 0, T_IDLE, 32'h4444_4444, 3'd2, 1, 1);
    chk("err1 HRESP", HRESP, 2'b01);
    chk("err1 HREADY_OUT", HREADY_OUT, 0);
    HRESET = 1'b1;
    #1;
    model_reset();
    chk("midrst HRESP", HRESP, 0);
    chk("midrst HREADY_OUT", HREADY_OUT, 1);
    chk("midrst VALID", VALID, 0);
    check_regs("midrst");
    @(posedge CLK);
    @(negedge CLK);
    HRESET = 1'b0; HTRANS = T_IDLE; APB_READY = 1'b1;
    #1;
    check_model_comb("postrst");
    check_regs("postrst");
    advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000 + $urandom_range(0, 15);
        1: a = 32'h8400_0000 + $urandom_range(0, 15);
        2: a = 32'h8800_0000 + $urandom_range(0, 15);
        3: a = 32'h8BFF_FFF0 + $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      drive(a, 1'($urandom), 2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 3)),
            ($urandom_range(0, 7) != 0), 1'($urandom));
      check_model_comb($sformatf("rnd%0d", n));
      check_regs($sformatf("rnd%0d", n));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 CLK  input  1  bridge clock; all state updates on the rising edge.
REQ-003 HRESET  input  1  asynchronous active-high reset.
REQ-004 HADDR  input  32  AHB address.
REQ-005 HWRITE  input  1  1=write, 0=read.
REQ-006 HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 HWDATA  input  32  AHB write data, one cycle after its address phase.
REQ-008 HSIZE  input  3  transfer size.
REQ-009 HREADY_IN  input  1  bus-wide ready.
REQ-010 APB_READY  input  1  downstream APB controller ready.
REQ-011 VALID  output  1  current address phase is a legal, selected transfer.
REQ-012 TEMP_SEL  output  3  one-hot peripheral select, decoded from HADDR.
REQ-013 HADDR_1, HADDR_2  output  32 each  address delayed 1 and 2 accepted cycles.
REQ-014 HWDATA_1, HWDATA_2  output  32 each  write data delayed 1 and 2 accepted cycles.
REQ-015 HWRITE_REG  output  1  HWRITE registered.
REQ-016 HREADY_OUT  output  1  slave ready to AHB.
REQ-017 HRESP  output  2  00 OKAY, 01 ERROR.

Function
REQ-018 Decode (combinational):
- 0x8000_0000-0x83FF_FFFF -> TEMP_SEL=001.
- 0x8400_0000-0x87FF_FFFF -> TEMP_SEL=010.
- 0x8800_0000-0x8BFF_FFFF -> TEMP_SEL=100.
- All other addresses -> TEMP_SEL=000.
REQ-019 Active transfer: HREADY_IN=1 and HTRANS is NONSEQ or SEQ.
REQ-020 Legal transfer: TEMP_SEL!=000, HSIZE<=010, and HADDR aligned to HSIZE.
- Size 01 requires HADDR[0]=0.
- Size 10 requires HADDR[1:0]=00.
REQ-021 VALID SHALL be combinational: 1 only for an active transfer that is legal, with the FSM in OKAY.
REQ-022 IDLE and BUSY SHALL give VALID=0 and raise no error, regardless of address.
REQ-023 Pipeline, on each rising CLK with HREADY_IN=1:
- HADDR_1<=HADDR, HADDR_2<=HADDR_1.
- HWDATA_1<=HWDATA, HWDATA_2<=HWDATA_1.
- HWRITE_REG<=HWRITE.
REQ-024 With HREADY_IN=0, all pipeline registers SHALL hold their values.
REQ-025 The response FSM SHALL have three states: OKAY, ERR1, ERR2.
REQ-026 OKAY outputs: HRESP=00, HREADY_OUT=APB_READY.
REQ-027 OKAY -> ERR1 on an active transfer that is not legal; otherwise the FSM stays in OKAY.
REQ-028 ERR1 outputs HRESP=01, HREADY_OUT=0; next state ERR2 unconditionally.
REQ-029 ERR2 outputs HRESP=01, HREADY_OUT=1; next state OKAY unconditionally.
REQ-030 HTRANS SHALL be ignored during ERR1 and ERR2: no VALID, no new error.
REQ-031 Error latency: ERROR response spans exactly the 2 cycles after the illegal address phase.
REQ-032 Back-to-back illegal transfers:
- The second illegal transfer is sampled only when the FSM is back in OKAY.
- It SHALL then start a new ERR1/ERR2 sequence.
REQ-033 The pipeline SHALL advance on HREADY_IN alone, independent of FSM state.

Reset
REQ-034 HRESET=1 SHALL immediately, without a clock edge:
- Clear HADDR_1, HADDR_2, HWDATA_1, HWDATA_2 and HWRITE_REG to 0.
- Force the FSM to OKAY, with HRESP=00 and HREADY_OUT=1.
REQ-035 While HRESET=1, HREADY_OUT SHALL stay 1 and VALID SHALL be 0.
REQ-036 Reset asserted during ERR1 or ERR2 SHALL abort the error: the first cycle after release is OKAY.

Verification
REQ-037 NONSEQ write, HADDR=0x8000_0010, HSIZE=010, HWDATA=0xA5A5_A5A5 next cycle, HREADY_IN=1 -> response:
- VALID=1, TEMP_SEL=001.
- HADDR_1=0x8000_0010 after 1 edge, HADDR_2 after 2 edges.
- HWDATA_1=0xA5A5_A5A5 one edge after data is driven.
REQ-038 NONSEQ read at 0x8400_0004, then at 0x8800_0008 -> response:
- TEMP_SEL=010, then 100.
- HWRITE_REG=0.
- HRESP stays 00.
REQ-039 NONSEQ at 0x9000_0000 -> response:
- VALID=0, TEMP_SEL=000.
- Next cycle HRESP=01, HREADY_OUT=0.
- Following cycle HRESP=01, HREADY_OUT=1.
- Then OKAY.
REQ-040 NONSEQ at 0x8000_0002 with HSIZE=010 -> error sequence identical to REQ-039.
REQ-041 HREADY_IN=0 for 3 cycles with changing HADDR -> HADDR_1 and HADDR_2 are unchanged across those cycles.
REQ-042 HRESET pulsed mid-ERR1 -> response:
- HRESP=00, HREADY_OUT=1 immediately.
- All pipeline registers read 0.
